reg_stream_sequencer: RTL and testbench
=======================================

# reg_stream_sequencer

Register-controlled AXI4-Stream burst sequencer that feeds the PS-side DMA engine (S2MM channel) with deterministic test-pattern beats. Software programs it through the PS output registers (control word, length/seed word) and reads progress and status back through the PS input registers. It sits in the PL between the block-design register interface and the DMA slave stream port, and sequences one burst per software start command.

## Interface
- `DATA_W`, 32: stream data width; fixed at 32 for this design.
- `LEN_W`, 16: beat-count width; the maximum burst length is 2^LEN_W − 1.
- `clk` in 1: PL fabric clock. Register interface and stream share this clock.
- `rst` in 1: asynchronous, active-high reset.
- `ctrl_reg` in 32: driven from PS output register 1.
  - [0] start: a rising edge launches a burst.
  - [1] abort: level-sensitive.
  - [3:2] pattern mode.
  - [31:16] seed.
- `len_reg` in 32: driven from PS output register 2. [LEN_W-1:0] is the beat count N; the upper bits are ignored.
- `status_reg` out 32: read back on a PS input register.
  - [0] busy.
  - [1] done.
  - [2] aborted.
  - [3] zero-length error.
  - [31:16] beats accepted.
- `cycle_reg` out 32: cycles from burst launch to completion; saturating.
- `m_axis_tdata` out DATA_W: stream data.
- `m_axis_tvalid` out 1: stream valid.
- `m_axis_tready` in 1: stream ready, from the DMA.
- `m_axis_tlast` out 1: marks the final beat of the burst.
- `irq_done` out 1: one-cycle pulse on burst completion.

## Operation
- **Start detection:** `ctrl_reg[0]` is registered once, and start = bit & ~prev.
  - A start edge while busy is ignored and does not queue.
- **States:**
  - **IDLE:** tvalid=0.
    - On start with N≠0: latch N, mode and seed; clear done/aborted/zero-length error, the beat count and `cycle_reg`. Go to RUN.
    - On start with N=0: set zero-length error and done, pulse `irq_done`, stay in IDLE.
  - **RUN:** tvalid=1 holding the current beat.
    - On a handshake (tvalid&tready) of the beat with tlast=1, go to DONE.
    - Otherwise a handshake advances to the next beat.
  - **DONE:** lasts one cycle. busy=0, done=1 (sticky), `irq_done`=1 for that cycle. Then go to IDLE.
- **Abort** (`ctrl_reg[1]`=1 sampled in RUN):
  - tvalid is never withdrawn and tdata never changes while unaccepted.
  - The currently presented beat is re-flagged tlast=1.
  - On its handshake: aborted=1 and done=1, then go to DONE.
  - Abort sampled in IDLE has no effect.
- **Patterns:** beat index k = 0..N−1, S = seed.
  - Mode 0: {16'h0, S} + k, modulo 2^32.
  - Mode 1: {S, S} for every beat.
  - Mode 2: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1.
    - Beat 0 = {S, ~S}, which is never zero.
    - Each beat advances the LFSR one step.
  - Mode 3: walking one. Beat 0 = 32'h1, rotated left by 1 each beat; 32'h80000000 wraps to 32'h1.
- **tlast:** asserted on beat k=N−1, or on the abort beat.
- **Counters:**
  - `status_reg[31:16]` increments on each handshake and holds its final value until the next launch.
  - `cycle_reg` counts every cycle in RUN, stalls included. It saturates at 32'hFFFFFFFF and holds after completion.

## Timing
- **Reset:** all outputs are 0 — `status_reg`=0, `cycle_reg`=0, tvalid=0, tlast=0, tdata=0, `irq_done`=0. State = IDLE and the start edge register = 0.
  - If `ctrl_reg[0]` is already 1 when reset releases, no burst launches; a fresh 0→1 edge is required.
- **Launch:** the start bit becomes 1 at cycle t and the edge is detected at t+1. tvalid=1 with beat 0 from t+2.
- **Throughput:** one beat per cycle while tready=1. The next beat is presented in the cycle after each handshake.
  - With tready held at 1, N beats occupy N consecutive cycles and `cycle_reg` = N.
- **Completion:** the final handshake occurs at cycle c. DONE is at c+1 (tvalid=0, `irq_done`=1), and IDLE follows at c+2.
- **Outputs:** all are registered; there is no combinational path from tready to tvalid/tdata.
- **Reset mid-burst:** tvalid drops immediately (asynchronously), all status is cleared, and no partial-burst indication is kept.
- **Abort and final beat together:** abort sampled on the final beat has tlast=1 either way. aborted=1 is set only if abort was sampled before the final handshake.

## Test plan
- **Incrementing burst:** N=4, mode 0, S=16'h0010, tready=1 → tdata 0x10, 0x11, 0x12, 0x13 on consecutive cycles; tlast on 0x13. `status_reg`=0x0004_0002, `cycle_reg`=4, one `irq_done` pulse.
- **Backpressure:** N=3, mode 3, tready toggling 1,0,1,0,… → beats 0x1, 0x2, 0x4 each held stable through stalls; `cycle_reg`=5, beat count = 3.
- **Abort:** N=100, mode 1, S=16'hABCD; abort raised after 10 handshakes → the 11th beat 0xABCDABCD carries tlast. status bits [2:1]=2'b11, beat count = 11.
- **Zero length:** N=0 → no tvalid ever; `status_reg`=0x0000_000A, one `irq_done` pulse.
- **Ignored restart and LFSR seed:** a start edge is given mid-burst with N=8, mode 2, S=16'h1234 → beat 0 = 0x1234EDCB; exactly 8 beats, with later beats matching the reference-model LFSR.
- **Reset mid-burst:** assert `rst` after 5 beats → tvalid=0 and `status_reg`=0 immediately; a subsequent start runs a clean full burst.

Source files
------------

// File: rtl/reg_stream_sequencer_if.sv
// Stream bundle between the burst sequencer and the DMA S2MM slave port.
// The master drives data, valid and last; the slave answers with ready.
interface reg_stream_sequencer_if #(
   parameter int DATA_W = 32
);

   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      output tready
   );

endinterface

// File: rtl/reg_stream_sequencer.sv
// Register-controlled AXI4-Stream burst sequencer.
// Software writes a control word (start edge, abort level, pattern mode, seed)
// and a beat count; the block then streams one deterministic test-pattern burst
// per start edge and reports progress, flags and elapsed cycles back through
// two read-only status words. All outputs come straight from flops.
module reg_stream_sequencer #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [31:0]                   ctrl_reg,
   input  logic [31:0]                   len_reg,
   output logic [31:0]                   status_reg,
   output logic [31:0]                   cycle_reg,
   reg_stream_sequencer_if.master        m_axis,
   output logic                          irq_done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   // Galois feedback mask for x^32 + x^22 + x^2 + x + 1, right-shifting form.
   localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

   state_t             state_q, state_d;

   // Start-edge detector: one sampling stage, its delayed copy, and an arm
   // flag that stays clear until the start bit has been seen low after reset.
   logic               sync_q, sync_d;
   logic               prev_q, prev_d;
   logic               arm_q, arm_d;
   logic               start_edge;

   // Burst parameters captured at launch.
   logic [LEN_W-1:0]   len_q, len_d;
   logic [1:0]         mode_q, mode_d;
   logic [15:0]        seed_q, seed_d;

   // Presented beat and its qualifiers.
   logic [DATA_W-1:0]  data_q, data_d;
   logic               valid_q, valid_d;
   logic               last_q, last_d;
   logic               abort_q, abort_d;

   // Progress counters and sticky status.
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        cycle_q, cycle_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               aborted_q, aborted_d;
   logic               zlen_q, zlen_d;
   logic               irq_q, irq_d;

   logic               handshake;
   logic [LEN_W-1:0]   req_len;
   logic               unused_bits;

   assign req_len     = len_reg[LEN_W-1:0];
   assign unused_bits = ^{len_reg[31:LEN_W], ctrl_reg[15:4]};

   // First beat of a burst for the requested pattern mode and seed.
   function automatic logic [DATA_W-1:0] first_beat(input logic [1:0] mode,
                                                    input logic [15:0] seed);
      logic [DATA_W-1:0] beat;
      case (mode)
         2'd0:    beat = {16'h0000, seed};
         2'd1:    beat = {seed, seed};
         2'd2:    beat = {seed, ~seed};
         default: beat = 32'h0000_0001;
      endcase
      return beat;
   endfunction

   // Beat that follows the current one in the selected pattern.
   function automatic logic [DATA_W-1:0] next_beat(input logic [1:0] mode,
                                                   input logic [DATA_W-1:0] cur);
      logic [DATA_W-1:0] beat;
      case (mode)
         2'd0:    beat = cur + 32'd1;
         2'd1:    beat = cur;
         2'd2:    beat = cur[0] ? ((cur >> 1) ^ LFSR_MASK) : (cur >> 1);
         default: beat = {cur[DATA_W-2:0], cur[DATA_W-1]};
      endcase
      return beat;
   endfunction

   assign start_edge = sync_q & ~prev_q & arm_q;
   assign handshake  = valid_q & m_axis.tready;

   // Next-state and datapath updates for the launch / stream / done sequence.
   always_comb begin
      state_d   = state_q;
      sync_d    = ctrl_reg[0];
      prev_d    = sync_q;
      arm_d     = arm_q | ~ctrl_reg[0];
      len_d     = len_q;
      mode_d    = mode_q;
      seed_d    = seed_q;
      data_d    = data_q;
      valid_d   = valid_q;
      last_d    = last_q;
      abort_d   = abort_q;
      cnt_d     = cnt_q;
      cycle_d   = cycle_q;
      busy_d    = busy_q;
      done_d    = done_q;
      aborted_d = aborted_q;
      zlen_d    = zlen_q;
      irq_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               if (req_len != '0) begin
                  len_d     = req_len;
                  mode_d    = ctrl_reg[3:2];
                  seed_d    = ctrl_reg[31:16];
                  data_d    = first_beat(ctrl_reg[3:2], ctrl_reg[31:16]);
                  valid_d   = 1'b1;
                  last_d    = (req_len == LEN_W'(1));
                  abort_d   = 1'b0;
                  cnt_d     = '0;
                  cycle_d   = '0;
                  busy_d    = 1'b1;
                  done_d    = 1'b0;
                  aborted_d = 1'b0;
                  zlen_d    = 1'b0;
                  state_d   = ST_RUN;
               end else begin
                  zlen_d    = 1'b1;
                  done_d    = 1'b1;
                  aborted_d = 1'b0;
                  cnt_d     = '0;
                  cycle_d   = '0;
                  irq_d     = 1'b1;
               end
            end
         end

         ST_RUN: begin
            if (cycle_q != 32'hFFFF_FFFF) begin
               cycle_d = cycle_q + 32'd1;
            end
            if (ctrl_reg[1]) begin
               abort_d = 1'b1;
            end
            if (handshake) begin
               cnt_d = cnt_q + LEN_W'(1);
               if (last_q) begin
                  valid_d   = 1'b0;
                  last_d    = 1'b0;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  aborted_d = abort_q;
                  irq_d     = 1'b1;
                  state_d   = ST_DONE;
               end else begin
                  data_d = next_beat(mode_q, data_q);
                  last_d = (cnt_q + LEN_W'(1) == len_q - LEN_W'(1))
                           | ctrl_reg[1] | abort_q;
               end
            end else if (ctrl_reg[1]) begin
               last_d = 1'b1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset clears every output immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sync_q    <= 1'b0;
         prev_q    <= 1'b0;
         arm_q     <= 1'b0;
         len_q     <= '0;
         mode_q    <= '0;
         seed_q    <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         abort_q   <= 1'b0;
         cnt_q     <= '0;
         cycle_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         zlen_q    <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         prev_q    <= prev_d;
         arm_q     <= arm_d;
         len_q     <= len_d;
         mode_q    <= mode_d;
         seed_q    <= seed_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         abort_q   <= abort_d;
         cnt_q     <= cnt_d;
         cycle_q   <= cycle_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         zlen_q    <= zlen_d;
         irq_q     <= irq_d;
      end
   end

   assign m_axis.tdata  = data_q;
   assign m_axis.tvalid = valid_q;
   assign m_axis.tlast  = last_q;
   assign irq_done      = irq_q;
   assign cycle_reg     = cycle_q;
   assign status_reg    = {16'(cnt_q), 12'h000, zlen_q, aborted_q, done_q, busy_q};

   // A presented beat is never withdrawn or altered before it is accepted.
   property p_hold_until_accepted;
      @(posedge clk) disable iff (rst)
         (m_axis.tvalid && !m_axis.tready) |=> (m_axis.tvalid && $stable(m_axis.tdata));
   endproperty
   a_hold_until_accepted: assert property (p_hold_until_accepted);

   // The completion interrupt is always a single-cycle pulse.
   property p_irq_single;
      @(posedge clk) disable iff (rst) irq_done |=> !irq_done;
   endproperty
   a_irq_single: assert property (p_irq_single);

endmodule

// File: tb/tb_reg_stream_sequencer.sv
// Self-checking bench for reg_stream_sequencer: a table of directed bursts,
// hand-written sequences for zero length, ignored restart and reset, and
// randomized bursts, all checked against a beat-index reference model.
module tb_reg_stream_sequencer;

   typedef struct {
      int          n;
      int          mode;
      logic [15:0] seed;
      int          readyMode;
      int          abortAfter;
      bit          restart;
      bit          hasExp;
      logic [31:0] expStatus;
      int          expCycle;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ctrl_reg;
   logic [31:0] len_reg;
   logic [31:0] status_reg;
   logic [31:0] cycle_reg;
   logic        irq_done;

   int errors = 0;
   int checks = 0;

   vec_t vecs[8];

   reg_stream_sequencer_if #(.DATA_W(32)) axis();

   reg_stream_sequencer #(.DATA_W(32), .LEN_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .ctrl_reg  (ctrl_reg),
      .len_reg   (len_reg),
      .status_reg(status_reg),
      .cycle_reg (cycle_reg),
      .m_axis    (axis),
      .irq_done  (irq_done)
   );

   // Free-running 100 MHz fabric clock.
   always #5 clk = ~clk;

   // Hard stop in case some wait is never satisfied.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int n, input int mode, input logic [15:0] seed,
                                input logic abortBit, input logic startBit);
      ctrl_reg = {seed, 12'h000, 2'(mode), abortBit, startBit};
      len_reg  = 32'(n);
   endtask

   function automatic logic [31:0] lfsrStep(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   // Beat k of a burst, straight from the pattern definitions.
   function automatic logic [31:0] modelBeat(input int mode, input logic [15:0] seed,
                                             input int k);
      logic [31:0] s;
      case (mode)
         0: s = {16'h0000, seed} + 32'(k);
         1: s = {seed, seed};
         2: begin
            s = {seed, ~seed};
            for (int i = 0; i < k; i++) s = lfsrStep(s);
         end
         default: s = 32'h1 << (k % 32);
      endcase
      return s;
   endfunction

   // Launches one burst and follows it to idle, checking every presented beat.
   task automatic runBurst(input vec_t v, output logic [31:0] firstData);
      int   hsCount;
      int   runCycles;
      int   budget;
      bit   abortRaised;
      bit   abortSeen;
      bit   finished;
      bit   expAborted;
      bit   r;
      logic expLast;
      logic [31:0] expStatus;

      hsCount = 0; runCycles = 0; budget = 0;
      abortRaised = 0; abortSeen = 0; finished = 0; expAborted = 0;
      firstData = '0;

      @(negedge clk);
      applyStimulus(v.n, v.mode, v.seed, 1'b0, 1'b0);
      axis.tready = 1'b1;
      @(negedge clk);
      applyStimulus(v.n, v.mode, v.seed, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("launch_gap_tvalid", 32'(axis.tvalid), 32'd0);

      while (!finished && budget < 4000) begin
         @(negedge clk);
         budget++;
         if (abortRaised) abortSeen = 1;
         if (!axis.tvalid) begin
            checkOutput("tvalid_during_burst", 32'(axis.tvalid), 32'd1);
            break;
         end
         runCycles++;
         if (runCycles == 1) begin
            checkOutput("launch_status", status_reg, 32'h0000_0001);
            firstData = axis.tdata;
         end
         case (v.readyMode)
            0:       r = 1'b1;
            1:       r = (runCycles % 2) == 1;
            3:       r = (runCycles % 2) == 0;
            default: r = 1'($urandom_range(0, 1));
         endcase
         axis.tready = r;
         checkOutput($sformatf("tdata k=%0d", hsCount), axis.tdata,
                     modelBeat(v.mode, v.seed, hsCount));
         expLast = (hsCount == v.n - 1) || abortSeen;
         checkOutput($sformatf("tlast k=%0d", hsCount), 32'(axis.tlast), 32'(expLast));
         if (v.restart && runCycles == 2) ctrl_reg[0] = 1'b0;
         if (v.restart && runCycles == 3) ctrl_reg[0] = 1'b1;
         if (r) begin
            hsCount++;
            if (expLast) begin
               finished   = 1;
               expAborted = abortSeen;
            end
         end
         if (!abortRaised && v.abortAfter >= 0 && hsCount >= v.abortAfter) begin
            ctrl_reg[1] = 1'b1;
            abortRaised = 1;
         end
      end
      checkOutput("burst_complete", 32'(finished), 32'd1);

      @(negedge clk);
      checkOutput("done_tvalid", 32'(axis.tvalid), 32'd0);
      checkOutput("done_irq", 32'(irq_done), 32'd1);
      checkOutput("done_flags", 32'(status_reg[3:0]), {28'h0, 1'b0, expAborted, 1'b1, 1'b0});
      ctrl_reg[1] = 1'b0;
      ctrl_reg[0] = 1'b0;

      @(negedge clk);
      checkOutput("idle_irq", 32'(irq_done), 32'd0);
      expStatus = {hsCount[15:0], 12'h000, 1'b0, expAborted, 1'b1, 1'b0};
      checkOutput("status", status_reg, expStatus);
      checkOutput("cycle", cycle_reg, 32'(runCycles));
      if (v.hasExp) begin
         checkOutput("status_table", status_reg, v.expStatus);
         checkOutput("cycle_table", cycle_reg, 32'(v.expCycle));
      end
      if (v.restart) begin
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("no_queued_start", 32'(axis.tvalid), 32'd0);
         end
      end
   endtask

   initial begin
      logic [31:0] firstData;
      vec_t        rv;
      int          validSeen;
      int          irqCount;
      int          hs;
      int          budget;

      // n, mode, seed, readyMode, abortAfter, restart, hasExp, expStatus, expCycle
      vecs[0] = '{4,   0, 16'h0010, 0, -1, 1'b0, 1'b1, 32'h0004_0002, 4};
      vecs[1] = '{3,   3, 16'h0000, 1, -1, 1'b0, 1'b1, 32'h0003_0002, 5};
      vecs[2] = '{100, 1, 16'hABCD, 0, 10, 1'b0, 1'b1, 32'h000B_0006, 11};
      vecs[3] = '{1,   2, 16'hFFFF, 0, -1, 1'b0, 1'b1, 32'h0001_0002, 1};
      vecs[4] = '{5,   3, 16'h0000, 3, 0,  1'b0, 1'b1, 32'h0001_0006, 2};
      vecs[5] = '{3,   0, 16'hFFFF, 0, 3,  1'b0, 1'b1, 32'h0003_0002, 3};
      vecs[6] = '{33,  3, 16'h0000, 0, -1, 1'b0, 1'b1, 32'h0021_0002, 33};
      vecs[7] = '{3,   0, 16'h0200, 0, 2,  1'b0, 1'b1, 32'h0003_0006, 3};

      rst         = 1'b1;
      ctrl_reg    = '0;
      len_reg     = '0;
      axis.tready = 1'b0;

      $display("[TB] reset state");
      #12;
      checkOutput("reset_status", status_reg, 32'h0);
      checkOutput("reset_cycle", cycle_reg, 32'h0);
      checkOutput("reset_tvalid", 32'(axis.tvalid), 32'd0);
      checkOutput("reset_tlast", 32'(axis.tlast), 32'd0);
      checkOutput("reset_tdata", axis.tdata, 32'h0);
      checkOutput("reset_irq", 32'(irq_done), 32'd0);

      // Start bit already high when reset releases: nothing may launch.
      applyStimulus(4, 0, 16'h0001, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      validSeen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (axis.tvalid) validSeen++;
      end
      checkOutput("no_launch_after_reset", 32'(validSeen), 32'd0);

      $display("[TB] directed burst table");
      for (int i = 0; i < 8; i++) begin
         runBurst(vecs[i], firstData);
      end

      $display("[TB] zero-length burst");
      @(negedge clk);
      applyStimulus(0, 0, 16'h5555, 1'b0, 1'b0);
      len_reg = 32'hABCD_0000;
      @(negedge clk);
      ctrl_reg[0] = 1'b1;
      validSeen = 0;
      irqCount  = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (axis.tvalid) validSeen++;
         if (irq_done) irqCount++;
      end
      checkOutput("zero_len_tvalid", 32'(validSeen), 32'd0);
      checkOutput("zero_len_irq_count", 32'(irqCount), 32'd1);
      checkOutput("zero_len_status", status_reg, 32'h0000_000A);
      ctrl_reg[0] = 1'b0;

      $display("[TB] ignored restart with LFSR pattern");
      rv = '{8, 2, 16'h1234, 0, -1, 1'b1, 1'b1, 32'h0008_0002, 8};
      runBurst(rv, firstData);
      checkOutput("lfsr_beat0", firstData, 32'h1234_EDCB);

      $display("[TB] reset mid-burst");
      @(negedge clk);
      applyStimulus(20, 0, 16'h0100, 1'b0, 1'b0);
      axis.tready = 1'b1;
      @(negedge clk);
      ctrl_reg[0] = 1'b1;
      hs = 0;
      budget = 0;
      while (hs < 5 && budget < 50) begin
         @(negedge clk);
         budget++;
         if (axis.tvalid) hs++;
      end
      checkOutput("pre_reset_beats", 32'(hs), 32'd5);
      #2 rst = 1'b1;
      #1;
      checkOutput("midreset_tvalid", 32'(axis.tvalid), 32'd0);
      checkOutput("midreset_status", status_reg, 32'h0);
      checkOutput("midreset_cycle", cycle_reg, 32'h0);
      checkOutput("midreset_tdata", axis.tdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      validSeen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (axis.tvalid) validSeen++;
      end
      checkOutput("held_start_after_reset", 32'(validSeen), 32'd0);
      rv = '{6, 0, 16'h0100, 0, -1, 1'b0, 1'b1, 32'h0006_0002, 6};
      runBurst(rv, firstData);

      $display("[TB] randomized bursts");
      for (int i = 0; i < 24; i++) begin
         rv.n          = $urandom_range(1, 40);
         rv.mode       = $urandom_range(0, 3);
         rv.seed       = 16'($urandom);
         rv.readyMode  = 2;
         rv.abortAfter = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rv.n)) : -1;
         rv.restart    = 1'b0;
         rv.hasExp     = 1'b0;
         rv.expStatus  = '0;
         rv.expCycle   = 0;
         runBurst(rv, firstData);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
